// File: rtl/main_decoder_if.sv
// main_decoder_if: opcode in, registered datapath controls out
interface main_decoder_if;
   logic [10:0] Op;
   logic        Reg2Loc;
   logic        ALUSrc;
   logic        MemtoReg;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        Branch;
   logic [1:0]  ALUOp;
   logic        Illegal;
   modport master (
      output Op,
      input  Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal
   );
   modport slave (
      input  Op,
      output Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal
   );
endinterface

// File: rtl/main_decoder.sv
// main_decoder: LEGv8 opcode to control-word decode, one-cycle registered
module main_decoder (
   input  logic           clk,
   input  logic           reset,
   main_decoder_if.slave  bus
);
   logic [9:0] ctl_d;
   logic [9:0] ctl_q;
   always_comb begin
      ctl_d = 10'b0000000001;
      case (bus.Op) inside
         11'b11111000010: ctl_d = 10'b0111100000;
         11'b11111000000: ctl_d = 10'b1100010000;
         11'b10110100???: ctl_d = 10'b1000001010;
         11'b10001011000,
         11'b11001011000,
         11'b10001010000,
         11'b10101010000: ctl_d = 10'b0001000100;
         default:         ctl_d = 10'b0000000001;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) ctl_q <= '0;
      else       ctl_q <= ctl_d;
   assign {bus.Reg2Loc, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
           bus.MemWrite, bus.Branch, bus.ALUOp, bus.Illegal} = ctl_q;
endmodule

// File: tb/tb_main_decoder.sv
// tb_main_decoder: directed opcodes with a scoreboard queue and a separate monitor
module tb_main_decoder;
   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;
   logic [9:0] sb_q[$];
   main_decoder_if bus ();
   main_decoder dut (.clk(clk), .reset(reset), .bus(bus));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   localparam int NV = 18;
   logic [10:0] v_op  [NV] = '{
      11'b11111000010, 11'b11111000000, 11'b10110100001, 11'b10110100010,
      11'b10110100100, 11'b10001011000, 11'b11001011000, 11'b10001010000,
      11'b10101010000, 11'b00000001111, 11'b11111111111, 11'b10110101000,
      11'b11111000011, 11'b10110100000, 11'b11111000010, 11'b00000000000,
      11'b10110100111, 11'b11111000000
   };
   // Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0] Illegal
   logic [9:0] v_exp [NV] = '{
      10'b0111100000, 10'b1100010000, 10'b1000001010, 10'b1000001010,
      10'b1000001010, 10'b0001000100, 10'b0001000100, 10'b0001000100,
      10'b0001000100, 10'b0000000001, 10'b0000000001, 10'b0000000001,
      10'b0000000001, 10'b1000001010, 10'b0111100000, 10'b0000000001,
      10'b1000001010, 10'b1100010000
   };
   string f_name [10] = '{"Reg2Loc", "ALUSrc", "MemtoReg", "RegWrite", "MemRead",
                          "MemWrite", "Branch", "ALUOp1", "ALUOp0", "Illegal"};
   function automatic logic [9:0] outs();
      return {bus.Reg2Loc, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
              bus.MemWrite, bus.Branch, bus.ALUOp, bus.Illegal};
   endfunction
   task automatic check(input string tag, input logic [9:0] act, input logic [9:0] exp);
      for (int b = 0; b < 10; b++) begin
         n_total++;
         if (act[9-b] !== exp[9-b])
            $display("FAIL %s.%s got=%b want=%b (word got=%b want=%b)",
                     tag, f_name[b], act[9-b], exp[9-b], act, exp);
         else n_pass++;
      end
   endtask
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            logic [9:0] a, e;
            e = sb_q.pop_front();
            a = outs();
            check($sformatf("decode_op_%b", bus.Op), a, e);
            n_total++;
            if ((32'(a[5]) + 32'(a[4]) + 32'(a[3])) > 1)
               $display("FAIL mutex MemRead/MemWrite/Branch got=%b%b%b want=at most one set",
                        a[5], a[4], a[3]);
            else n_pass++;
         end
      end
   end
   task automatic drain(input string tag);
      for (int i = 0; i < 6 && sb_q.size() != 0; i++) @(negedge clk);
      n_total++;
      if (sb_q.size() != 0) $display("FAIL %s drain got=%0d pending want=0", tag, sb_q.size());
      else n_pass++;
   endtask
   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      bus.Op  = 11'b11111000010;
      #1;
      check("reset_async_noclk", outs(), 10'b0);
      @(posedge clk);
      #1;
      check("reset_held_edge", outs(), 10'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NV; i++) begin
         bus.Op = v_op[i];
         sb_q.push_back(v_exp[i]);
         @(negedge clk);
      end
      drain("stream");
      #2 reset = 1'b1;
      #1;
      check("reset_midstream", outs(), 10'b0);
      @(negedge clk);
      check("reset_midstream_edge", outs(), 10'b0);
      reset = 1'b0;
      bus.Op = 11'b11111000000;
      sb_q.push_back(10'b1100010000);
      @(negedge clk);
      bus.Op = 11'b10101010000;
      sb_q.push_back(10'b0001000100);
      @(negedge clk);
      drain("post_reset");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
